// File: rtl/go_stop_scheduler_pkg.sv
// Shared types for the go/stop scheduler: FSM state labels, requester ids
// and a one-hot grant helper.
package sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GO   = 2'd1,
        RUN  = 2'd2,
        STOP = 2'd3
    } state_e;

    typedef logic req_id_t;

    localparam req_id_t FSM1_ID = 1'b0;
    localparam req_id_t FSM2_ID = 1'b1;

    function automatic logic [1:0] id_onehot(input req_id_t id);
        return (id == FSM2_ID) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/go_stop_scheduler_hold_timer.sv
// Saturating RUN-cycle counter for the go/stop scheduler; limit_hit flags the
// last allowed RUN cycle (count == MAX_HOLD-1).
module hold_timer #(
    parameter int MAX_HOLD = 16
) (
    input  logic clock,
    input  logic resetN,
    input  logic clear,
    input  logic enable,
    output logic limit_hit
);

    localparam int CNT_W = $clog2(MAX_HOLD) + 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_HOLD - 1);

    logic [CNT_W-1:0] count_q, count_d;

    assign limit_hit = (count_q == LIMIT);

    // Saturates at LIMIT so the count can never wrap back to zero.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && !limit_hit) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/go_stop_scheduler.sv
// Two-requester go/stop scheduler with round-robin contention resolution.
// Optional forced release after MAX_HOLD RUN cycles: GO_STOP_SCHEDULER_TIMEOUT_EN.
module go_stop_scheduler
    import sched_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic       clock,
    input  logic       resetN,
    input  logic [1:0] req,
    input  logic [1:0] done,
    output logic [1:0] gnt,
    output logic       go,
    output logic       busy,
    output logic       last_owner,
    output logic       timeout
);

    state_e  state_q, state_d;
    req_id_t owner_q, owner_d;
    req_id_t last_owner_q, last_owner_d;
    logic    timeout_q, timeout_d;
    logic    limit_hit;

`ifdef GO_STOP_SCHEDULER_TIMEOUT_EN
    hold_timer #(
        .MAX_HOLD (MAX_HOLD)
    ) u_hold_timer (
        .clock     (clock),
        .resetN    (resetN),
        .clear     (state_q == STOP),
        .enable    (state_q == RUN),
        .limit_hit (limit_hit)
    );
`else
    assign limit_hit = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        timeout_d    = timeout_q;
        case (state_q)
            IDLE: begin
                timeout_d = 1'b0;
                if (req != 2'b00) begin
                    state_d = GO;
                    // Contention goes to whoever did not own the resource last.
                    case (req)
                        2'b01:   owner_d = FSM1_ID;
                        2'b10:   owner_d = FSM2_ID;
                        default: owner_d = ~last_owner_q;
                    endcase
                end
            end
            GO: begin
                state_d = RUN;
            end
            RUN: begin
                if (done[owner_q]) begin
                    state_d   = STOP;
                    timeout_d = 1'b0;
                end else if (limit_hit) begin
                    state_d   = STOP;
                    timeout_d = 1'b1;
                end
            end
            STOP: begin
                last_owner_d = owner_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q      <= IDLE;
            owner_q      <= FSM1_ID;
            last_owner_q <= FSM2_ID;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            timeout_q    <= timeout_d;
        end
    end

    assign gnt        = ((state_q == GO) || (state_q == RUN)) ? id_onehot(owner_q) : 2'b00;
    assign go         = (state_q == GO);
    assign busy       = (state_q != IDLE);
    assign last_owner = last_owner_q;
    assign timeout    = (state_q == STOP) && timeout_q;

endmodule
